pixel_window_gen: RTL and testbench
===================================

Name: pixel_window_gen

Overview:
- Writer side of the 3x3 blur path: accepts the raster pixel stream from camera capture and builds a 3x3 neighbourhood per pixel for the blur filters.
- Holds two line buffers plus a 3x3 column shift window.
- Emits one window per image pixel with centre coordinates, edge handling and an end-of-frame flush.
- Sits between capture and the blur selector/filters, replacing their need to address frame memory directly.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=3)
- IMG_HEIGHT, 480, lines per frame (>=3)
- PIX_W, 12, bits per pixel (RGB444)

Ports:
- writeClk  in  1  sole clock
- resetN  in  1  async active-low reset
- frameStart  in  1  one-cycle pulse before pixel (0,0); restarts counters
- pixelIn  in  PIX_W  incoming pixel
- pixelValid  in  1  pixelIn valid this cycle (raster order)
- winPixels  out  9*PIX_W  window; slice k=col*3+row, col l/m/r=0/1/2, row u/m/d=0/1/2 (k0=lu, k4=mm, k8=rd)
- winValid  out  1  winPixels/winX/winY valid this cycle
- winX  out  10  centre column
- winY  out  9  centre row
- frameDone  out  1  one-cycle pulse with the last window of a frame
- overflow  out  1  sticky; set when a pixel is dropped

Behaviour:
- Reset (async assert, sync release): winValid=0, winPixels=0, winX=0, winY=0, frameDone=0, overflow=0, FSM=IDLE, counters=0.
- FSM states: IDLE, STREAM, TAIL, FLUSH.
- frameStart wins in every state: go to STREAM, x=y=0, clear window.
- frameStart does not clear overflow; only reset clears it.
- IDLE:
  - pixelValid ignored.
- STREAM:
  - Each pixelValid: write pixel (x,y) to line buffer; shift column {buf[y-2][x], buf[y-1][x], pixelIn} into window right column.
  - x increments and wraps at IMG_WIDTH-1 to 0; y then increments.
- Window emission (latency 1 cycle, registered):
  - When pixel (x,y) is accepted with x>=1 and y>=1, the next cycle gives winValid=1 with centre (x-1,y-1).
  - On accepting (IMG_WIDTH-1,y) with y>=1, go to TAIL.
  - In TAIL, emit centre (IMG_WIDTH-1,y-1) next cycle, then return to STREAM.
  - If y==IMG_HEIGHT-1, go from TAIL to FLUSH instead.
- TAIL:
  - pixelValid in TAIL: pixel dropped, overflow=1.
  - Line blanking guarantees at least one idle cycle between lines.
- FLUSH:
  - Emits row IMG_HEIGHT-1, one window per cycle, columns 0..IMG_WIDTH-1.
  - pixelValid is ignored and sets overflow.
  - frameDone pulses with window (IMG_WIDTH-1, IMG_HEIGHT-1), then go to IDLE.
- Edge handling (default): any neighbour outside the image is replaced by the centre pixel (mm). Applies to:
  - row u at winY=0
  - row d at winY=IMG_HEIGHT-1
  - col l at winX=0
  - col r at winX=IMG_WIDTH-1
  - all combinations at corners
- Pixels beyond IMG_WIDTH*IMG_HEIGHT before the next frameStart are dropped and set overflow.
- Reset mid-frame: all outputs clear asynchronously; line buffer contents are don't-care; the next frameStart is required.
- Arithmetic: x is 10-bit, y is 9-bit unsigned; no saturation, wrap via compare.

Optional Feature:
- Macro: PIXEL_WINDOW_EDGE_ZERO_EN.
- Defined: out-of-image neighbours read as 0 instead of the replicated centre.
- Undefined: centre replication as above.
- Only the edge mux changes; timing is identical.

Decomposition:
- Package pixel_pkg:
  - PIX_W
  - pixel_t typedef
  - window index constants WIN_LU..WIN_RD (0..8)
  - FSM state enum
- Sub-module pixel_line_buffer:
  - single-clock, IMG_WIDTH x PIX_W
  - one write port, one synchronous read port
  - instantiated twice (rows y-1, y-2)
  - buffer rotation toggled at each line wrap

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3, pixel value = y*16+x):
- Full frame, 1 idle cycle between lines:
  - exactly 12 winValid pulses, raster order (0,0)..(3,2)
  - frameDone pulses only with (3,2)
  - overflow=0
- Centre window (1,1):
  - winPixels lu..rd = 0x000, 0x010, 0x020, 0x001, 0x011, 0x021, 0x002, 0x012, 0x022
- Corner (0,0), default build:
  - lu, lm, mu = 0x000; ld = 0x000; rd = 0x011
- Corner (0,0), PIXEL_WINDOW_EDGE_ZERO_EN build:
  - lu, lm, ld, mu, ru = 0
  - md = 0x010, rm = 0x001, rd = 0x011
- Pixel driven in the TAIL cycle after (3,1):
  - pixel dropped, overflow=1 and stays 1 through the next frameStart
- resetN low during FLUSH:
  - winValid, frameDone go 0 immediately
  - no windows until the next frameStart
  - the following clean frame reproduces scenario 1

Source files
------------

// File: rtl/pixel_pkg.sv
// pixel_pkg: shared pixel type, 3x3 window slice indices and window FSM states
package pixel_pkg;
  localparam int PIX_W = 12;
  typedef logic [PIX_W-1:0] pixel_t;
  localparam int WIN_LU = 0;
  localparam int WIN_LM = 1;
  localparam int WIN_LD = 2;
  localparam int WIN_MU = 3;
  localparam int WIN_MM = 4;
  localparam int WIN_MD = 5;
  localparam int WIN_RU = 6;
  localparam int WIN_RM = 7;
  localparam int WIN_RD = 8;
  typedef enum logic [1:0] {IDLE, STREAM, TAIL, FLUSH} state_t;
endpackage

// File: rtl/pixel_line_buffer.sv
// pixel_line_buffer: one image line of pixels, one write port and one registered read port
module pixel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int PIX_W = 12,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [PIX_W-1:0] wrData,
  input  logic [AW-1:0]    rdAddr,
  output logic [PIX_W-1:0] rdData
);
  import pixel_pkg::*;
  logic [PIX_W-1:0] mem [DEPTH];
  // write the incoming pixel; read returns the stored word one cycle later
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    rdData <= mem[rdAddr];
  end
endmodule

// File: rtl/pixel_window_gen.sv
// pixel_window_gen: builds a 3x3 neighbourhood per raster pixel with edge handling and end-of-frame flush
// Optional: define PIXEL_WINDOW_EDGE_ZERO_EN to read out-of-image neighbours as 0 instead of the centre.
module pixel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 12
) (
  input  logic               writeClk,
  input  logic               resetN,
  input  logic               frameStart,
  input  logic [PIX_W-1:0]   pixelIn,
  input  logic               pixelValid,
  output logic [9*PIX_W-1:0] winPixels,
  output logic               winValid,
  output logic [9:0]         winX,
  output logic [8:0]         winY,
  output logic               frameDone,
  output logic               overflow
);
  import pixel_pkg::*;
  localparam int AW = $clog2(IMG_WIDTH);
  localparam logic [9:0] X_LAST = 10'(IMG_WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(IMG_HEIGHT - 1);
  localparam logic [8:0] Y_END = 9'(IMG_HEIGHT);
  state_t state, stateN;
  logic [9:0] x, xN, winXN;
  logic [8:0] y, yN, winYN;
  logic sel, accept, lastX, lastY, shift, winValidN, frameDoneN, ovfSet;
  logic [PIX_W-1:0] rd [2];
  logic [PIX_W-1:0] win [9];
  logic [PIX_W-1:0] fill;
  assign accept = state == STREAM && pixelValid && !frameStart;
  assign lastX = x == X_LAST;
  assign lastY = y == Y_LAST;
  assign shift = accept || state == TAIL || state == FLUSH;
`ifdef PIXEL_WINDOW_EDGE_ZERO_EN
  assign fill = '0;
`else
  assign fill = win[WIN_MM];
`endif
  // two lines rotate: buffer sel takes the current line while holding row y-2, the other holds row y-1;
  // reads are prefetched at the next column so data is ready when that pixel arrives
  for (genvar i = 0; i < 2; i++) begin : g_buf
    pixel_line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W), .AW(AW)) u_buf (
      .clk(writeClk),
      .wrEn(accept && sel == 1'(i)),
      .wrAddr(x[AW-1:0]),
      .wrData(pixelIn),
      .rdAddr(xN[AW-1:0]),
      .rdData(rd[i])
    );
  end
  // state register
  always_ff @(posedge writeClk or negedge resetN)
    if (!resetN) state <= IDLE;
    else state <= stateN;
  // next state: frameStart restarts from any state
  always_comb
    stateN = frameStart ? STREAM :
             state == STREAM ? (accept && lastX && y != 0 ? TAIL : STREAM) :
             state == TAIL ? (lastY ? FLUSH : STREAM) :
             state == FLUSH ? (x == 0 ? IDLE : FLUSH) : IDLE;
  // next column/row; the TAIL before FLUSH already pulls column 0 of the last row into the window
  always_comb begin
    xN = x;
    yN = y;
    if (frameStart) begin
      xN = '0;
      yN = '0;
    end else if (accept) begin
      xN = lastX ? '0 : x + 10'd1;
      yN = lastX && y == 0 ? 9'd1 : y;
    end else if (state == TAIL) begin
      xN = lastY ? 10'd1 : '0;
      yN = y + 9'd1;
    end else if (state == FLUSH) xN = lastX ? '0 : x + 10'd1;
  end
  // window outputs for the next cycle; FLUSH at x==0 is the final window of the frame
  always_comb begin
    winValidN = !frameStart && ((accept && x != 0 && y != 0) || state == TAIL || state == FLUSH);
    frameDoneN = !frameStart && state == FLUSH && x == 0;
    winXN = state == TAIL || x == 0 ? X_LAST : x - 10'd1;
    winYN = state == FLUSH ? Y_LAST : y - 9'd1;
    ovfSet = !frameStart && pixelValid && (state == TAIL || state == FLUSH || (state == IDLE && y == Y_END));
  end
  // counters, line rotation, column shift window and registered window outputs
  always_ff @(posedge writeClk or negedge resetN)
    if (!resetN) begin
      x <= '0;
      y <= '0;
      sel <= 1'b0;
      winValid <= 1'b0;
      frameDone <= 1'b0;
      winX <= '0;
      winY <= '0;
      overflow <= 1'b0;
      win <= '{default: '0};
    end else begin
      x <= xN;
      y <= yN;
      if (accept && lastX) sel <= ~sel;
      winValid <= winValidN;
      frameDone <= frameDoneN;
      if (winValidN) begin
        winX <= winXN;
        winY <= winYN;
      end
      if (ovfSet) overflow <= 1'b1;
      if (frameStart) win <= '{default: '0};
      else if (shift) begin
        win[WIN_LU] <= win[WIN_MU];
        win[WIN_LM] <= win[WIN_MM];
        win[WIN_LD] <= win[WIN_MD];
        win[WIN_MU] <= win[WIN_RU];
        win[WIN_MM] <= win[WIN_RM];
        win[WIN_MD] <= win[WIN_RD];
        win[WIN_RU] <= rd[sel];
        win[WIN_RM] <= rd[~sel];
        win[WIN_RD] <= pixelIn;
      end
    end
  // edge mux: neighbours outside the image take the fill value
  always_comb begin
    winPixels = '0;
    for (int k = 0; k < 9; k++)
      winPixels[k*PIX_W +: PIX_W] = (k < 3 && winX == 0) || (k > 5 && winX == X_LAST) ||
                                    (k % 3 == 0 && winY == 0) || (k % 3 == 2 && winY == Y_LAST) ? fill : win[k];
  end
endmodule

// File: tb/tb_pixel_window_gen.sv
// tb_pixel_window_gen: table vectors, random frames against a neighbourhood model, reset and overflow corners
module tb_pixel_window_gen;
  localparam int W = 4;
  localparam int H = 3;
  localparam int PW = 12;
  logic writeClk = 1'b0;
  logic resetN = 1'b0;
  logic frameStart = 1'b0;
  logic pixelValid = 1'b0;
  logic [PW-1:0] pixelIn = '0;
  logic [9*PW-1:0] winPixels;
  logic winValid, frameDone, overflow;
  logic [9:0] winX;
  logic [8:0] winY;
  typedef struct {int x; int y; logic [9*PW-1:0] p; logic fd;} win_t;
  typedef struct {int cx; int cy; logic [9*PW-1:0] exp;} vec_t;
  win_t obs[$];
  vec_t tbl[5];
  int fdCnt = 0;
  int img[H][W];
  int nChecks = 0;
  int nPass = 0;

  pixel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
    .writeClk(writeClk), .resetN(resetN), .frameStart(frameStart), .pixelIn(pixelIn),
    .pixelValid(pixelValid), .winPixels(winPixels), .winValid(winValid), .winX(winX),
    .winY(winY), .frameDone(frameDone), .overflow(overflow)
  );

  always #5 writeClk = ~writeClk;

  // collect every emitted window away from the active edge
  always @(negedge writeClk)
    if (resetN) begin
      if (winValid) obs.push_back('{int'(winX), int'(winY), winPixels, frameDone});
      if (frameDone) fdCnt++;
    end

  function automatic logic [9*PW-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {PW'(a8), PW'(a7), PW'(a6), PW'(a5), PW'(a4), PW'(a3), PW'(a2), PW'(a1), PW'(a0)};
  endfunction

  // neighbourhood of (cx,cy) taken straight from the image, outside pixels replaced
  function automatic logic [9*PW-1:0] model(input int cx, input int cy);
    logic [9*PW-1:0] r;
    r = '0;
    for (int c = 0; c < 3; c++)
      for (int rr = 0; rr < 3; rr++) begin
        int nx, ny, v;
        nx = cx + c - 1;
        ny = cy + rr - 1;
        if (nx < 0 || nx >= W || ny < 0 || ny >= H)
`ifdef PIXEL_WINDOW_EDGE_ZERO_EN
          v = 0;
`else
          v = img[cy][cx];
`endif
        else v = img[ny][nx];
        r[(c*3+rr)*PW +: PW] = PW'(v);
      end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge writeClk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic sendPix(input int v);
    pixelValid = 1'b1;
    pixelIn = PW'(v);
    tick();
    pixelValid = 1'b0;
  endtask

  task automatic startFrame();
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
  endtask

  task automatic setPattern();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = y * 16 + x;
  endtask

  task automatic setRandom();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = int'($urandom_range(0, 4095));
  endtask

  task automatic driveFrame(input bit rnd, input bit tailPix);
    startFrame();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        sendPix(img[y][x]);
        if (rnd && x < W - 1) idle(int'($urandom_range(0, 2)));
      end
      if (tailPix && y == 1) sendPix('hABC);
      idle(rnd ? int'($urandom_range(1, 3)) : 1);
    end
  endtask

  task automatic checkFrame(input string tag);
    chk({tag, " count"}, obs.size(), W * H);
    for (int i = 0; i < obs.size() && i < W * H; i++) begin
      chk($sformatf("%s win%0d x", tag, i), obs[i].x, i % W);
      chk($sformatf("%s win%0d y", tag, i), obs[i].y, i / W);
      chk($sformatf("%s win%0d pixels", tag, i), obs[i].p, model(i % W, i / W));
      chk($sformatf("%s win%0d frameDone", tag, i), obs[i].fd, i == W * H - 1);
    end
    chk({tag, " frameDone pulses"}, fdCnt, 1);
    obs.delete();
    fdCnt = 0;
  endtask

  initial begin
    tbl[0] = '{1, 1, pk('h000, 'h010, 'h020, 'h001, 'h011, 'h021, 'h002, 'h012, 'h022)};
    tbl[1] = '{2, 1, pk('h001, 'h011, 'h021, 'h002, 'h012, 'h022, 'h003, 'h013, 'h023)};
    tbl[2] = '{0, 0, pk('h000, 'h000, 'h000, 'h000, 'h000, 'h010, 'h000, 'h001, 'h011)};
`ifdef PIXEL_WINDOW_EDGE_ZERO_EN
    tbl[3] = '{3, 0, pk(0, 'h002, 'h012, 0, 'h003, 'h013, 0, 0, 0)};
    tbl[4] = '{3, 2, pk('h012, 'h022, 0, 'h013, 'h023, 0, 0, 0, 0)};
`else
    tbl[3] = '{3, 0, pk('h003, 'h002, 'h012, 'h003, 'h003, 'h013, 'h003, 'h003, 'h003)};
    tbl[4] = '{3, 2, pk('h012, 'h022, 'h023, 'h013, 'h023, 'h023, 'h023, 'h023, 'h023)};
`endif
    repeat (2) @(posedge writeClk);
    #1;
    chk("reset winValid", winValid, 0);
    chk("reset winPixels", winPixels, 0);
    chk("reset winX", winX, 0);
    chk("reset winY", winY, 0);
    chk("reset frameDone", frameDone, 0);
    chk("reset overflow", overflow, 0);
    resetN = 1'b1;
    tick();
    repeat (3) sendPix(7);
    idle(2);
    chk("idle before frame windows", obs.size(), 0);
    chk("idle before frame overflow", overflow, 0);
    setPattern();
    driveFrame(0, 0);
    idle(W + 3);
    for (int v = 0; v < 5; v++) begin
      bit found;
      logic [9*PW-1:0] got;
      found = 0;
      got = '0;
      foreach (obs[j])
        if (obs[j].x == tbl[v].cx && obs[j].y == tbl[v].cy) begin
          found = 1;
          got = obs[j].p;
        end
      chk($sformatf("vec(%0d,%0d) present", tbl[v].cx, tbl[v].cy), found, 1);
      chk($sformatf("vec(%0d,%0d) pixels", tbl[v].cx, tbl[v].cy), got, tbl[v].exp);
    end
    checkFrame("pattern");
    chk("pattern overflow", overflow, 0);
    for (int f = 0; f < 3; f++) begin
      setRandom();
      driveFrame(1, 0);
      idle(W + 3);
      checkFrame($sformatf("rand%0d", f));
      chk($sformatf("rand%0d overflow", f), overflow, 0);
    end
    setPattern();
    driveFrame(0, 0);
    tick();
    chk("flush emitting", winValid, 1);
    #2 resetN = 1'b0;
    #1;
    chk("async reset winValid", winValid, 0);
    chk("async reset frameDone", frameDone, 0);
    chk("async reset winY", winY, 0);
    chk("async reset winPixels", winPixels, 0);
    idle(2);
    resetN = 1'b1;
    obs.delete();
    fdCnt = 0;
    repeat (4) sendPix(9);
    idle(3);
    chk("no windows after reset", obs.size(), 0);
    driveFrame(0, 0);
    idle(W + 3);
    checkFrame("after reset");
    chk("after reset overflow", overflow, 0);
    sendPix(5);
    idle(1);
    chk("pixel beyond frame overflow", overflow, 1);
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    tick();
    chk("reset clears overflow", overflow, 0);
    driveFrame(0, 1);
    idle(W + 3);
    checkFrame("tail drop");
    chk("tail drop overflow", overflow, 1);
    startFrame();
    chk("overflow through frameStart", overflow, 1);
    driveFrame(0, 0);
    idle(W + 3);
    checkFrame("after drop");
    chk("overflow sticky", overflow, 1);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
